// File: rtl/dm_access_arbiter.sv
// Two-master arbiter in front of the single-ported data memory: grant, access, response.
// Checks alignment/range, lane-positions store data and extends load data.
module dm_access_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
  parameter int          FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_size,
  input  logic        m0_sext,
  input  logic [31:0] m0_pc,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_size,
  input  logic        m1_sext,
  input  logic [31:0] m1_pc,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic [1:0]  mem_wlen,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        cmd_we_p0, cmd_sext_p0, cmd_id_p0;
  logic [31:0] cmd_addr_p0, cmd_wdata_p0, cmd_pc_p0;
  logic [1:0]  cmd_size_p0;
  logic        err_p0;
  logic [1:0]  vld_p1;
  logic        err_p1;
  logic [31:0] rdata_p1;

  function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [1:0] size,
                                              input logic [1:0] ofs);
    if (size == 2'd0 || size == 2'd1) store_lanes = wdata << {ofs, 3'b000};
    else store_lanes = wdata;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] rd, input logic [1:0] size,
                                               input logic [1:0] ofs, input logic sext);
    logic [31:0] sh;
    sh = rd >> {ofs, 3'b000};
    case (size)
      2'd0:    load_extract = {{24{sext & sh[7]}}, sh[7:0]};
      2'd1:    load_extract = {{16{sext & sh[15]}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // last_grant==1 means m1 went last, so m0 is owed the next tie
          if (m0_req && (!m1_req || FIXED_PRIO != 0 || last_grant)) m0_gnt = 1'b1;
          else m1_gnt = 1'b1;
          state_nxt = ACCESS;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // grant stage: latch the winner's command
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant   <= 1'b1;
      cmd_we_p0    <= 1'b0;
      cmd_sext_p0  <= 1'b0;
      cmd_id_p0    <= 1'b0;
      cmd_addr_p0  <= '0;
      cmd_wdata_p0 <= '0;
      cmd_pc_p0    <= '0;
      cmd_size_p0  <= '0;
    end else if (m0_gnt || m1_gnt) begin
      last_grant   <= m1_gnt;
      cmd_id_p0    <= m1_gnt;
      cmd_we_p0    <= m1_gnt ? m1_we    : m0_we;
      cmd_sext_p0  <= m1_gnt ? m1_sext  : m0_sext;
      cmd_addr_p0  <= m1_gnt ? m1_addr  : m0_addr;
      cmd_wdata_p0 <= m1_gnt ? m1_wdata : m0_wdata;
      cmd_pc_p0    <= m1_gnt ? m1_pc    : m0_pc;
      cmd_size_p0  <= m1_gnt ? m1_size  : m0_size;
    end
  end

  always_comb begin
    err_p0 = (cmd_size_p0 == 2'd3) ||
             (cmd_size_p0 == 2'd1 && cmd_addr_p0[0]) ||
             (cmd_size_p0 == 2'd2 && cmd_addr_p0[1:0] != 2'b00) ||
             (cmd_addr_p0 >= ADDR_LIMIT);
  end

  // access stage: memory side is driven straight from the held command
  always_comb begin
    mem_a  = cmd_addr_p0;
    mem_pc = cmd_pc_p0;
    mem_wd = store_lanes(cmd_wdata_p0, cmd_size_p0, cmd_addr_p0[1:0]);
    mem_we = (state == ACCESS) && cmd_we_p0 && !err_p0;
    case (cmd_size_p0)
      2'd1:    mem_wlen = 2'd1;
      2'd2:    mem_wlen = 2'd3;
      default: mem_wlen = 2'd0;
    endcase
  end

  // response stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= '0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else if (state == ACCESS) begin
      vld_p1   <= cmd_id_p0 ? 2'b10 : 2'b01;
      err_p1   <= err_p0;
      rdata_p1 <= (cmd_we_p0 || err_p0) ? 32'h0 :
                  load_extract(mem_rd, cmd_size_p0, cmd_addr_p0[1:0], cmd_sext_p0);
    end else begin
      vld_p1   <= '0;
      err_p1   <= 1'b0;
      rdata_p1 <= '0;
    end
  end

  assign m0_rvalid = vld_p1[0];
  assign m1_rvalid = vld_p1[1];
  assign m0_err    = vld_p1[0] & err_p1;
  assign m1_err    = vld_p1[1] & err_p1;
  assign m0_rdata  = vld_p1[0] ? rdata_p1 : 32'h0;
  assign m1_rdata  = vld_p1[1] ? rdata_p1 : 32'h0;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter; a second instance runs with fixed priority.
module tb_dm_access_arbiter;

  logic        clk, reset;
  logic        m0_req, m0_we, m0_sext, m1_req, m1_we, m1_sext;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata, m1_pc, mem_rd;
  logic [1:0]  m0_size, m1_size;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_pc;
  logic [1:0]  mem_wlen;
  logic        f0_gnt, f0_rvalid, f0_err, f1_gnt, f1_rvalid, f1_err, f_mem_we;
  logic [31:0] f0_rdata, f1_rdata, f_mem_a, f_mem_wd, f_mem_pc;
  logic [1:0]  f_mem_wlen;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;

  dm_access_arbiter #(.ADDR_LIMIT(32'h0000_1000), .FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_sext(m0_sext), .m0_pc(m0_pc), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_sext(m1_sext), .m1_pc(m1_pc), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_err(m1_err),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_wlen(mem_wlen), .mem_pc(mem_pc),
    .mem_rd(mem_rd)
  );

  dm_access_arbiter #(.ADDR_LIMIT(32'h0000_1000), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_size(m0_size),
    .m0_sext(m0_sext), .m0_pc(m0_pc), .m0_gnt(f0_gnt), .m0_rvalid(f0_rvalid), .m0_rdata(f0_rdata),
    .m0_err(f0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_size(m1_size),
    .m1_sext(m1_sext), .m1_pc(m1_pc), .m1_gnt(f1_gnt), .m1_rvalid(f1_rvalid), .m1_rdata(f1_rdata),
    .m1_err(f1_err),
    .mem_a(f_mem_a), .mem_wd(f_mem_wd), .mem_we(f_mem_we), .mem_wlen(f_mem_wlen), .mem_pc(f_mem_pc),
    .mem_rd(mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (mem_we === 1'b1) wr_count <= wr_count + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic sext, input logic [31:0] pc);
    if (m == 0) begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_size = size; m0_sext = sext; m0_pc = pc;
      m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_size = size; m1_sext = sext; m1_pc = pc;
      m1_req = 1'b1;
    end
  endtask

  task automatic drop();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b want=00", {m0_gnt, m1_gnt}); end
    checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) begin errors++; $display("FAIL reset_rvalid_err got=%b want=0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h want=0", m0_rdata, m1_rdata); end
    checks++; if (mem_we !== 1'b0 || mem_wlen !== 2'd0) begin errors++; $display("FAIL reset_we_wlen got=%b/%0d want=0/0", mem_we, mem_wlen); end
    checks++; if (mem_a !== 32'h0 || mem_wd !== 32'h0 || mem_pc !== 32'h0) begin errors++; $display("FAIL reset_mem got=%h/%h/%h want=0", mem_a, mem_wd, mem_pc); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_word_store();
    int wc;
    wc = wr_count;
    issue(0, 1'b1, 32'h10, 32'h1234_5678, 2'd2, 1'b0, 32'h0000_0100);
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL wst_gnt got=%b want=10", {m0_gnt, m1_gnt}); end
    step(); drop();
    checks++; if (mem_a !== 32'h10) begin errors++; $display("FAIL wst_mem_a got=%h want=10", mem_a); end
    checks++; if (mem_wd !== 32'h1234_5678) begin errors++; $display("FAIL wst_mem_wd got=%h want=12345678", mem_wd); end
    checks++; if (mem_wlen !== 2'd3 || mem_we !== 1'b1) begin errors++; $display("FAIL wst_wlen_we got=%0d/%b want=3/1", mem_wlen, mem_we); end
    checks++; if (mem_pc !== 32'h100) begin errors++; $display("FAIL wst_mem_pc got=%h want=100", mem_pc); end
    checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL wst_no_gnt_access got=%b want=00", {m0_gnt, m1_gnt}); end
    step();
    checks++; if ({m0_rvalid, m1_rvalid, m0_err} !== 3'b100) begin errors++; $display("FAIL wst_resp got=%b want=100", {m0_rvalid, m1_rvalid, m0_err}); end
    checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL wst_rdata got=%h want=0", m0_rdata); end
    checks++; if (wr_count !== wc + 1) begin errors++; $display("FAIL wst_writes got=%0d want=%0d", wr_count, wc + 1); end
    checks++; if (mem_we !== 1'b0 || mem_a !== 32'h10) begin errors++; $display("FAIL wst_hold got=%b/%h want=0/10", mem_we, mem_a); end
  endtask

  task automatic test_byte_store();
    issue(1, 1'b1, 32'h5, 32'h0000_00AB, 2'd0, 1'b0, 32'h0000_0200);
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL bst_gnt got=%b want=01", {m0_gnt, m1_gnt}); end
    step(); drop();
    checks++; if (mem_wd !== 32'h0000_AB00) begin errors++; $display("FAIL bst_mem_wd got=%h want=0000ab00", mem_wd); end
    checks++; if (mem_wlen !== 2'd0 || mem_we !== 1'b1 || mem_a !== 32'h5) begin errors++; $display("FAIL bst_ctrl got=%0d/%b/%h want=0/1/5", mem_wlen, mem_we, mem_a); end
    step();
    checks++; if ({m0_rvalid, m1_rvalid, m1_err} !== 3'b010) begin errors++; $display("FAIL bst_resp got=%b want=010", {m0_rvalid, m1_rvalid, m1_err}); end
    step();
    checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL bst_pulse got=%b want=00", {m0_rvalid, m1_rvalid}); end
  endtask

  task automatic test_loads();
    logic [31:0] addrs [3] = '{32'h6, 32'h6, 32'h3};
    logic [1:0]  sizes [3] = '{2'd1, 2'd1, 2'd0};
    logic        sexts [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] exps  [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80};
    for (int i = 0; i < 3; i++) begin
      mem_rd = 32'h8001_1234;
      issue(0, 1'b0, addrs[i], 32'h0, sizes[i], sexts[i], 32'h300);
      #1;
      checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL ld%0d_gnt got=%b want=1", i, m0_gnt); end
      step(); drop();
      checks++; if (mem_we !== 1'b0 || mem_a !== addrs[i]) begin errors++; $display("FAIL ld%0d_access got=%b/%h want=0/%h", i, mem_we, mem_a, addrs[i]); end
      step();
      checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== exps[i]) begin
        errors++; $display("FAIL ld%0d_resp got=%b/%b/%h want=1/0/%h", i, m0_rvalid, m0_err, m0_rdata, exps[i]);
      end
    end
    mem_rd = 32'h0;
  endtask

  task automatic test_round_robin();
    reset = 1'b0; step(); reset = 1'b1; step();
    issue(0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 32'h400);
    issue(1, 1'b0, 32'h4, 32'h0, 2'd2, 1'b0, 32'h500);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c % 2 == 1) begin
        checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin errors++; $display("FAIL rr_c%0d got=%b want=00", c, {m0_gnt, m1_gnt}); end
      end else if (c % 4 == 0) begin
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rr_c%0d got=%b want=10", c, {m0_gnt, m1_gnt}); end
      end else begin
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL rr_c%0d got=%b want=01", c, {m0_gnt, m1_gnt}); end
      end
      checks++; if ({f0_gnt, f1_gnt} !== ((c % 2 == 0) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL fp_c%0d got=%b want=%b", c, {f0_gnt, f1_gnt}, (c % 2 == 0) ? 2'b10 : 2'b00);
      end
      @(posedge clk);
    end
    #1; drop();
    step(); step();
  endtask

  task automatic test_errors();
    int wc;
    wc = wr_count;
    issue(0, 1'b1, 32'h2, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h600);
    step(); drop();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL err_st_we got=%b want=0", mem_we); end
    step();
    checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin
      errors++; $display("FAIL err_st_resp got=%b/%b/%h want=1/1/0", m0_rvalid, m0_err, m0_rdata);
    end
    mem_rd = 32'hFFFF_FFFF;
    issue(0, 1'b0, 32'h1001, 32'h0, 2'd1, 1'b1, 32'h700);
    step(); drop();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL err_ld_we got=%b want=0", mem_we); end
    step();
    checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin
      errors++; $display("FAIL err_ld_resp got=%b/%b/%h want=1/1/0", m0_rvalid, m0_err, m0_rdata);
    end
    checks++; if (wr_count !== wc) begin errors++; $display("FAIL err_writes got=%0d want=%0d", wr_count, wc); end
    mem_rd = 32'h0;
  endtask

  task automatic test_reset_mid_access();
    int wc;
    wc = wr_count;
    issue(0, 1'b1, 32'h20, 32'h0000_DEAD, 2'd2, 1'b0, 32'h800);
    step(); drop();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rma_we_before got=%b want=1", mem_we); end
    reset = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rma_we_drop got=%b want=0", mem_we); end
    step();
    checks++; if (wr_count !== wc) begin errors++; $display("FAIL rma_writes got=%0d want=%0d", wr_count, wc); end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rma_rvalid_c%0d got=%b want=00", c, {m0_rvalid, m1_rvalid}); end
      step();
    end
    issue(0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 32'h900);
    issue(1, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 32'h900);
    #1;
    checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL rma_first_gnt got=%b want=10", {m0_gnt, m1_gnt}); end
    step(); drop();
    step(); step();
  endtask

  initial begin
    reset = 1'b0; mem_rd = 32'h0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_size = '0; m0_sext = 1'b0; m0_pc = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_size = '0; m1_sext = 1'b0; m1_pc = '0;
    test_reset();
    test_word_store();
    test_byte_store();
    test_loads();
    test_round_robin();
    test_errors();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
